// File: rtl/instr_dma_loader.sv
// Instruction source stage: host loads words by address, then they are
// streamed to the core in address order over a valid/ready handshake.
module instr_dma_loader #(
    parameter int ABIT  = 6,
    parameter int NBIT  = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            request,
    input  logic [ABIT-1:0] addr,
    input  logic [NBIT-1:0] wr_data,
    input  logic            wr_en,
    input  logic            fetch_ready,
    output logic [NBIT-1:0] instr_out,
    output logic            instr_valid,
    output logic [ABIT-1:0] pc,
    output logic            acknowledge,
    output logic            addr_err,
    output logic            done
);

    localparam int IW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_FETCH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [NBIT-1:0] r_mem [0:DEPTH];
    logic [NBIT-1:0] r_instr;
    logic            r_valid;
    logic [ABIT-1:0] r_pc;
    logic [ABIT-1:0] r_last;
    logic            r_ack;
    logic            r_err;
    logic            r_done;

    logic            w_addr_ok;
    logic            w_wr_ok;
    logic [IW-1:0]   w_wr_idx;
    logic [ABIT-1:0] w_next_pc;
    logic [IW-1:0]   w_rd_idx;

    // Entry 0 is reserved; only 1..DEPTH are ever written or read.
    assign w_addr_ok = (addr != {ABIT{1'b0}}) && (addr <= ABIT'(DEPTH));
    assign w_wr_ok   = rst && (r_state == S_LOAD) && request && wr_en && w_addr_ok;
    assign w_wr_idx  = addr[IW-1:0];
    assign w_next_pc = r_pc + ABIT'(1);
    assign w_rd_idx  = w_next_pc[IW-1:0];

    // Instruction store write port (contents survive reset).
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_instr <= {NBIT{1'b0}};
            r_valid <= 1'b0;
            r_pc    <= {ABIT{1'b0}};
            r_last  <= {ABIT{1'b0}};
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (request) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // A write on the same edge request drops is ignored.
                    if (request) begin
                        if (wr_en) begin
                            if (w_addr_ok) begin
                                r_ack <= 1'b1;
                                if (addr > r_last) begin
                                    r_last <= addr;
                                end
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end else if (r_last != {ABIT{1'b0}}) begin
                        r_state <= S_PRIME;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pc    <= r_last;
                    end
                end
                S_PRIME: begin
                    if (request) begin
                        r_state <= S_LOAD;
                        r_valid <= 1'b0;
                    end else begin
                        r_instr <= r_mem[IW'(1)];
                        r_pc    <= ABIT'(1);
                        r_valid <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (request) begin
                        r_state <= S_LOAD;
                        r_valid <= 1'b0;
                    end else if (fetch_ready) begin
                        if (r_pc < r_last) begin
                            r_instr <= r_mem[w_rd_idx];
                            r_pc    <= w_next_pc;
                        end else begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    if (request) begin
                        r_state <= S_LOAD;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign acknowledge = r_ack;
    assign addr_err    = r_err;
    assign done        = r_done;

endmodule

// File: tb/tb_instr_dma_loader.sv
// Directed bench for instr_dma_loader: load, stream, backpressure, bad
// addresses, empty load, abort and mid-stream reset.
module tb_instr_dma_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        request;
    logic [5:0]  addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        fetch_ready;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [5:0]  pc;
    logic        acknowledge;
    logic        addr_err;
    logic        done;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_mem [0:16];
    int          hs;
    int          exp_pc;
    logic        exp_v;
    logic        rdy_seq [0:5];

    instr_dma_loader dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .addr        (addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .fetch_ready (fetch_ready),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .acknowledge (acknowledge),
        .addr_err    (addr_err),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one write in LOAD and check the response pulse on the next cycle.
    task automatic write(input int a, input logic [31:0] d);
        logic ok;
        ok      = (a >= 1) && (a <= 16);
        addr    = a[5:0];
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        check("ack", {31'd0, acknowledge}, {31'd0, ok});
        check("addr_err", {31'd0, addr_err}, {31'd0, ~ok});
        if (ok) exp_mem[a] = d;
    endtask

    // Drop request with fetch_ready=1 and follow a full stream of 'last' words.
    task automatic stream_all(input int last);
        request     = 1'b0;
        fetch_ready = 1'b1;
        tick();
        check("prime_valid", {31'd0, instr_valid}, 32'd0);
        for (int k = 1; k <= last; k++) begin
            tick();
            check("s_valid", {31'd0, instr_valid}, 32'd1);
            check("s_pc", {26'd0, pc}, k);
            check("s_word", instr_out, exp_mem[k]);
        end
        tick();
        check("s_done", {31'd0, done}, 32'd1);
        check("s_valid_end", {31'd0, instr_valid}, 32'd0);
        check("s_pc_end", {26'd0, pc}, last);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        request = 1'b0;
        wr_en = 1'b0;
        fetch_ready = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] pat(input int a);
        if (a == 1) return 32'hFFFF_FFFF;
        else if (a <= 3) return a - 1;
        else if (a == 4) return 32'h0000_0000;
        else return a - 2;
    endfunction

    initial begin
        for (int i = 0; i <= 16; i++) exp_mem[i] = 32'h0;
        addr = 6'd0;
        wr_data = 32'h0;
        do_reset();
        tick();
        check("rst_instr", instr_out, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", {26'd0, pc}, 32'd0);
        check("rst_ack", {31'd0, acknowledge}, 32'd0);
        check("rst_err", {31'd0, addr_err}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // Load and stream all 16 words.
        request = 1'b1;
        tick();
        for (int a = 1; a <= 16; a++) write(a, pat(a));
        stream_all(16);

        // Backpressure with 3 words.
        do_reset();
        request = 1'b1;
        tick();
        write(1, 32'hA5A5_A5A5);
        write(2, 32'h5A5A_5A5A);
        write(3, 32'h0000_FFFF);
        request = 1'b0;
        tick();
        check("bp_prime", {31'd0, instr_valid}, 32'd0);
        tick();
        check("bp_first", instr_out, 32'hA5A5_A5A5);
        rdy_seq[0] = 1'b0; rdy_seq[1] = 1'b0; rdy_seq[2] = 1'b1;
        rdy_seq[3] = 1'b0; rdy_seq[4] = 1'b1; rdy_seq[5] = 1'b1;
        hs = 0;
        exp_pc = 1;
        exp_v = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fetch_ready = rdy_seq[i];
            if (instr_valid && fetch_ready) hs++;
            tick();
            if (rdy_seq[i]) begin
                if (exp_pc < 3) exp_pc++;
                else exp_v = 1'b0;
            end
            check("bp_valid", {31'd0, instr_valid}, {31'd0, exp_v});
            if (exp_v) begin
                check("bp_pc", {26'd0, pc}, exp_pc);
                check("bp_word", instr_out, exp_mem[exp_pc]);
            end
        end
        check("bp_handshakes", hs, 32'd3);
        check("bp_done", {31'd0, done}, 32'd1);

        // Boundary addresses and duplicate write, then a 16-word stream.
        do_reset();
        request = 1'b1;
        fetch_ready = 1'b0;
        tick();
        write(0, 32'hDEAD_0000);
        write(17, 32'hDEAD_0017);
        write(16, 32'h1234_5678);
        write(2, 32'h1111_1111);
        write(2, 32'h2222_2222);
        check("dup_model", exp_mem[2], 32'h2222_2222);
        check("b16_model", exp_mem[16], 32'h1234_5678);
        stream_all(16);

        // Empty load: done without ever raising instr_valid.
        do_reset();
        request = 1'b1;
        tick();
        request = 1'b0;
        tick();
        check("empty_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("empty_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end

        // Abort at pc=5.
        request = 1'b1;
        tick();
        check("reload_done", {31'd0, done}, 32'd0);
        for (int a = 1; a <= 6; a++) write(a, 32'h0000_0100 + a);
        request = 1'b0;
        fetch_ready = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("ab_pc", {26'd0, pc}, k);
            check("ab_word", instr_out, exp_mem[k]);
        end
        request = 1'b1;
        tick();
        check("ab_valid", {31'd0, instr_valid}, 32'd0);
        write(7, 32'h0000_0077);

        // Restart, then reset at pc=3.
        request = 1'b0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("rs_pc", {26'd0, pc}, k);
        end
        rst = 1'b0;
        tick();
        check("mid_instr", instr_out, 32'h0);
        check("mid_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_pc", {26'd0, pc}, 32'd0);
        check("mid_ack", {31'd0, acknowledge}, 32'd0);
        check("mid_err", {31'd0, addr_err}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        request = 1'b1;
        tick();
        write(1, 32'hCAFE_F00D);
        stream_all(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_dma_loader.md
Name: instr_dma_loader

Overview:
- Upstream instruction-source stage that feeds the processor core.
- In load mode (request=1), the host writes instruction words into a local DEPTH-entry store by address, and the block acknowledges each write.
- In fetch mode (request=0), it streams the stored words in address order (1..last written) to the core over a valid/ready handshake.
- It then signals done.

Parameters:
- ABIT, 6, address width.
- NBIT, 32, instruction word width.
- DEPTH, 16, number of stored words; valid addresses are 1..DEPTH, and address 0 is reserved.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- request  in  1  1 = load mode, 0 = fetch mode.
- addr  in  ABIT  write address (load mode).
- wr_data  in  NBIT  word to write.
- wr_en  in  1  write strobe, sampled only when request=1.
- fetch_ready  in  1  core can accept instr_out this cycle.
- instr_out  out  NBIT  current instruction to the core.
- instr_valid  out  1  instr_out is valid.
- pc  out  ABIT  address of the word on instr_out.
- acknowledge  out  1  one-cycle pulse after an accepted write.
- addr_err  out  1  one-cycle pulse after a write to address 0 or above DEPTH.
- done  out  1  stream complete; held high until the block leaves DONE.

Behaviour:
- Reset is synchronous, active-low: rst=0 at a rising clk edge has the following effect.
  - state becomes IDLE.
  - instr_out, instr_valid, pc, acknowledge, addr_err, done all become 0.
  - last_addr becomes 0.
  - Memory contents are not cleared.
  - Reset overrides every other input, including mid-stream; instr_valid is 0 in the cycle after reset.
- States:
  - IDLE:
    - Goes to LOAD when request=1; otherwise stays in IDLE.
  - LOAD:
    - Write accept: each cycle with wr_en=1 and 1<=addr<=DEPTH writes mem[addr]=wr_data. acknowledge pulses on the next cycle, and last_addr becomes max(last_addr, addr).
    - Invalid address: a write to an out-of-range address is dropped, and addr_err pulses on the next cycle instead of acknowledge.
    - Repeated address: the last write to an address wins.
    - Leaving LOAD: when request=0, the block goes to PRIME if last_addr!=0, or to DONE if last_addr==0. In the second case it never asserts instr_valid.
    - Same-edge priority: wr_en in the same cycle as request=0 is ignored, and no acknowledge follows.
  - PRIME (1 cycle):
    - Registered read: instr_out<=mem[1], pc<=1, instr_valid<=1; then goes to FETCH.
    - Fetch latency is 2 cycles from request falling to instr_valid=1.
  - FETCH:
    - Hold: instr_out and pc are held stable while instr_valid=1 and fetch_ready=0.
    - Advance: on fetch_ready=1 with pc<last_addr, the block loads instr_out<=mem[pc+1] and pc<=pc+1. instr_valid stays 1, so it sustains one word per cycle back-to-back.
    - Final word: on fetch_ready=1 with pc==last_addr, the block goes to DONE with instr_valid<=0.
  - DONE:
    - done=1, instr_valid=0, and pc holds last_addr.
    - request=1 goes to LOAD and clears done. Memory and last_addr are retained, so a reload overwrites or appends.
- Abort: request=1 during PRIME or FETCH goes to LOAD next cycle with instr_valid<=0. Any word presented in that cycle with fetch_ready=1 counts as consumed, but no further word is issued.
- acknowledge and addr_err are never both high, and both are 0 outside the cycle after a write attempt.
- pc wraps never: pc is bounded by last_addr<=DEPTH, so there is no modular arithmetic on pc.

Test Plan:
- Load and stream:
  - Stimulus: reset; request=1; write addr 1..16 with the values FFFFFFFF, 00000001, 00000002, 00000000, 00000003, 00000004, ...; hold fetch_ready=1; request=0.
  - Required response: acknowledge pulses 16 times; instr_valid rises 2 cycles after request falls; instr_out carries FFFFFFFF, 00000001, 00000002, ... on consecutive cycles with pc=1..16; done=1 the cycle after pc=16 is accepted.
- Backpressure:
  - Stimulus: 3 words loaded (A5A5A5A5, 5A5A5A5A, 0000FFFF); fetch_ready toggles 0,0,1,0,1,1.
  - Required response: each word stays stable until a ready cycle; exactly 3 handshakes occur; then done=1.
- Boundary addresses:
  - Stimulus: writes to addr 0 and addr 17, then addr 16 = 12345678.
  - Required response: addr_err pulses twice and no acknowledge for those two writes; acknowledge follows for addr 16; last_addr=16; the stream runs 16 words with word 16 = 12345678.
- Empty and duplicate:
  - Stimulus: request falls with nothing written.
  - Required response: done=1 within 1 cycle and instr_valid never rises.
  - Stimulus: addr 2 is written with 11111111 then 22222222.
  - Required response: the stream shows 22222222 at pc=2.
- Abort and reset mid-stream:
  - Stimulus: request=1 at pc=5.
  - Required response: instr_valid=0 next cycle and the block is in LOAD.
  - Stimulus: restart the stream, then rst=0 at pc=3.
  - Required response: all outputs are 0 next cycle; after rst=1 and request=1, a new load works normally.
